// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared types and helpers for the tristate bus arbiter.
package arb_pkg;

    typedef enum logic [1:0] {IDLE, OWN, TURN} arb_state_t;

    // Width needed to hold a counter value in the range 0..max_hold.
    function automatic int hold_w(input int max_hold);
        return $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Request/enable bundle between the bus drivers and the arbiter.
interface tristate_bus_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] owner;
    logic             bus_busy;
    logic             preempt;

    // Requester side: raises req, watches its enable.
    modport master (
        output req,
        input  grant,
        input  owner,
        input  bus_busy,
        input  preempt
    );

    // Arbiter side: samples req, drives the enables and status.
    modport slave (
        input  req,
        output grant,
        output owner,
        output bus_busy,
        output preempt
    );
endinterface

// File: rtl/tristate_bus_arbiter_rr_picker.sv
// Combinational round-robin search: first requester above `last`, wrapping.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    // Scan last+1, last+2, ... modulo N_REQ; the first hit wins.
    always_comb begin
        int idx;
        idx     = 0;
        winner  = '0;
        any_req = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last) + i) % N_REQ;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tristate bus: one enable at a time, a
// one-cycle all-off turnaround between owners, and a hold limit that
// preempts a long tenure when someone else is waiting.
module tristate_bus_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tristate_bus_arbiter_if.slave bus
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int HOLD_W = hold_w(MAX_HOLD);

    arb_state_t        state, state_n;
    logic [N_REQ-1:0]  grant_q, grant_n;
    logic [IDX_W-1:0]  owner_q, owner_n;
    logic [IDX_W-1:0]  last_q, last_n;
    logic [HOLD_W-1:0] hold_q, hold_n;
    logic              busy_q, busy_n;
    logic              preempt_q, preempt_n;

    logic [IDX_W-1:0]  winner;
    logic              any_req;
    logic              own_req;
    logic              others_waiting;
    logic              hold_sat;

    // The same picker serves both the IDLE and the TURN decision.
    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req     (bus.req),
        .last    (last_q),
        .winner  (winner),
        .any_req (any_req)
    );

    assign own_req        = bus.req[owner_q];
    assign others_waiting = |(bus.req & ~grant_q);
    assign hold_sat       = (hold_q == HOLD_W'(MAX_HOLD));

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_n   = state;
        grant_n   = grant_q;
        owner_n   = owner_q;
        last_n    = last_q;
        hold_n    = hold_q;
        preempt_n = 1'b0;

        case (state)
            IDLE, TURN: begin
                grant_n = '0;
                state_n = IDLE;
                if (any_req) begin
                    state_n         = OWN;
                    grant_n[winner] = 1'b1;
                    owner_n         = winner;
                    last_n          = winner;
                    hold_n          = HOLD_W'(1);
                end
            end
            OWN: begin
                // A voluntary release takes precedence over hold expiry,
                // so a simultaneous drop never reports a preemption.
                if (!own_req) begin
                    state_n = TURN;
                    grant_n = '0;
                end else if (hold_sat && others_waiting) begin
                    state_n   = TURN;
                    grant_n   = '0;
                    preempt_n = 1'b1;
                end else if (!hold_sat) begin
                    hold_n = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase

        busy_n = |grant_n;
    end

    // State and output registers; reset drops every enable immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            last_q    <= IDX_W'(N_REQ - 1);
            hold_q    <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state     <= state_n;
            grant_q   <= grant_n;
            owner_q   <= owner_n;
            last_q    <= last_n;
            hold_q    <= hold_n;
            busy_q    <= busy_n;
            preempt_q <= preempt_n;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.owner    = owner_q;
    assign bus.bus_busy = busy_q;
    assign bus.preempt  = preempt_q;

endmodule
